// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 INCR burst initiator driven by a local command port
//
// Optional feature macro: AXI_BURST_MASTER_STATS_EN
//   defined   : stat_rd_beats / stat_wr_beats count R / W handshakes (32-bit, wrap, reset-only clear)
//   undefined : both stat outputs tied to 0
//
// Ports
//   clk_if, resetn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_rd/cmd_addr/cmd_len   one command -> one INCR burst (len = beats-1)
//   wr_data/wr_strb/wr_valid/wr_ready             write payload stream (passed to W channel)
//   rd_data/rd_last/rd_valid/rd_ready             read payload stream (from R channel)
//   done_valid/done_resp            one-cycle completion pulse with AXI resp encoding
//   stat_rd_beats/stat_wr_beats     beat counters
//   m_axi_aw*/w*/b*/ar*/r*          AXI4 master port

`ifndef DDR_DATA_WIDTH
`define DDR_DATA_WIDTH 128
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module axi_burst_master #(
    parameter int DATA_WIDTH = `DDR_DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int ID_WIDTH   = `ID_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk_if,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic [31:0]           stat_rd_beats,
    output logic [31:0]           stat_wr_beats,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic [3:0]            m_axi_awregion,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic [3:0]            m_axi_arregion,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int SIZE = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic [1:0]              resp_q;
    logic [ADDR_WIDTH-1:0]   cmd_addr_al;
    logic [31:0]             span_end;
    logic                    cmd_fire, cross_4k, r_fire, w_fire, last_beat;
    logic [1:0]              r_beat_resp;
    logic                    unused_ids;

    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    assign cmd_fire    = cmd_valid && (state == S_IDLE);
    assign cmd_addr_al = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
    // End offset of the burst within its 4KB page; anything past 4096 crosses the page.
    assign span_end    = 32'(cmd_addr_al[11:0]) + (32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH);
    assign cross_4k    = span_end > 32'd4096;
    assign last_beat   = (cnt_q == len_q);
    assign r_fire      = (state == S_R) && m_axi_rvalid && rd_ready;
    assign w_fire      = (state == S_W) && wr_valid && m_axi_wready;

    // Running worst-case read status including this beat; a misplaced rlast counts as SLVERR.
    always_comb begin
        r_beat_resp = m_axi_rresp;
        if ((m_axi_rlast != last_beat) && (r_beat_resp < 2'b10)) r_beat_resp = 2'b10;
        if (resp_q > r_beat_resp) r_beat_resp = resp_q;
    end

    always_ff @(posedge clk_if) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (cmd_fire && !cross_4k) state_next = cmd_rd ? S_AR : S_AW;
            S_AR:   if (m_axi_arready) state_next = S_R;
            S_R:    if (r_fire && last_beat) state_next = S_IDLE;
            S_AW:   if (m_axi_awready) state_next = S_W;
            S_W:    if (w_fire && last_beat) state_next = S_B;
            S_B:    if (m_axi_bvalid) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state == S_IDLE);
        m_axi_arvalid = (state == S_AR);
        m_axi_awvalid = (state == S_AW);
        rd_valid      = (state == S_R) && m_axi_rvalid;
        m_axi_rready  = (state == S_R) && rd_ready;
        rd_last       = (state == S_R) && last_beat;
        m_axi_wvalid  = (state == S_W) && wr_valid;
        wr_ready      = (state == S_W) && m_axi_wready;
        m_axi_wlast   = (state == S_W) && last_beat;
        m_axi_bready  = (state == S_B);
    end

    always_ff @(posedge clk_if) begin
        if (!resetn) begin
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            resp_q     <= '0;
            done_valid <= 1'b0;
            done_resp  <= 2'b00;
        end else begin
            done_valid <= 1'b0;
            if (cmd_fire) begin
                addr_q <= cmd_addr_al;
                len_q  <= cmd_len;
                cnt_q  <= '0;
                resp_q <= 2'b00;
                if (cross_4k) begin
                    done_valid <= 1'b1;
                    done_resp  <= 2'b10;
                end
            end
            if (r_fire) begin
                resp_q <= r_beat_resp;
                if (last_beat) begin
                    done_valid <= 1'b1;
                    done_resp  <= r_beat_resp;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
            if (w_fire && !last_beat) cnt_q <= cnt_q + 8'd1;
            if ((state == S_B) && m_axi_bvalid) begin
                done_valid <= 1'b1;
                done_resp  <= m_axi_bresp;
            end
        end
    end

`ifdef AXI_BURST_MASTER_STATS_EN
    logic [31:0] stat_rd_q, stat_wr_q;
    always_ff @(posedge clk_if) begin
        if (!resetn) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            if (r_fire) stat_rd_q <= stat_rd_q + 32'd1;
            if (w_fire) stat_wr_q <= stat_wr_q + 32'd1;
        end
    end
    assign stat_rd_beats = stat_rd_q;
    assign stat_wr_beats = stat_wr_q;
`else
    assign stat_rd_beats = '0;
    assign stat_wr_beats = '0;
`endif

    assign m_axi_awid     = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = len_q;
    assign m_axi_awsize   = 3'(SIZE);
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'd0;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_arid     = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = len_q;
    assign m_axi_arsize   = 3'(SIZE);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'd0;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_wdata    = wr_data;
    assign m_axi_wstrb    = wr_strb;
    assign rd_data        = m_axi_rdata;

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - randomized self-checking bench for axi_burst_master
module tb_axi_burst_master;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int SW = 16;

    logic clk_if = 1'b0;
    always #5 clk_if = ~clk_if;

    logic resetn;
    logic cmd_valid, cmd_ready, cmd_rd;
    logic [AW-1:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic rd_last, rd_valid, rd_ready;
    logic done_valid;
    logic [1:0] done_resp;
    logic [31:0] stat_rd_beats, stat_wr_beats;
    logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0] m_axi_awlen, m_axi_arlen;
    logic [2:0] m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic m_axi_awlock, m_axi_arlock;
    logic [3:0] m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos, m_axi_awregion, m_axi_arregion;
    logic m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [SW-1:0] m_axi_wstrb;
    logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic m_axi_bvalid, m_axi_bready;
    logic m_axi_rlast, m_axi_rvalid, m_axi_rready;

    axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW), .AXI_ID(0)) dut (
        .clk_if(clk_if), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_resp(done_resp),
        .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_rd_stats = 0;
    int exp_wr_stats = 0;
    logic [1:0] bresp_cfg;
    logic [DW-1:0] wmem [256];
    logic [DW-1:0] rmem [256];

    // observations of the last run_cmd
    int ob_wbeats, ob_rbeats, ob_data_err, ob_last_err, ob_done_t, ob_aw_seen, ob_ar_seen;
    logic [1:0] ob_resp;
    logic ob_done_after, ob_ready_at_done, ob_busy_ready;
    logic [AW-1:0] ob_addr;
    logic [7:0] ob_len;
    logic [2:0] ob_size;
    logic [1:0] ob_burst;

    // ---------------- reference model ----------------
    function automatic bit model_cross(input logic [AW-1:0] a, input int len);
        int base;
        base = int'(a[11:0]) - (int'(a[11:0]) % SW);
        return (base + (len + 1) * SW) > 4096;
    endfunction

    function automatic logic [1:0] model_read_resp(input int len, input int err_beat, input int err_val, input int early_beat);
        int r;
        bit slave_last;
        r = 0;
        for (int i = 0; i <= len; i++) begin
            slave_last = (early_beat >= 0) ? (i == early_beat) : (i == len);
            if (i == err_beat && err_val > r) r = err_val;
            if (slave_last != (i == len) && r < 2) r = 2;
        end
        return 2'(r);
    endfunction

    function automatic int stat_exp(input int v);
`ifdef AXI_BURST_MASTER_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic clear_inputs();
        cmd_valid = 0; cmd_rd = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;
        m_axi_awready = 0; m_axi_arready = 0; m_axi_wready = 0;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
    endtask

    // Drives one command and plays the AXI slave and stream endpoints; entry at posedge+1.
    task automatic run_cmd(input bit rd, input logic [AW-1:0] addr, input logic [7:0] len,
                           input int err_beat, input int err_val, input int early_beat,
                           input bit toggle, input int reset_wbeat);
        int wb, rb, t;
        bit ar_ok, wdone, hold_r, hold_b;
        for (int i = 0; i < 256; i++) begin
            wmem[i] = {$urandom, $urandom, $urandom, $urandom};
            rmem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        ob_wbeats = 0; ob_rbeats = 0; ob_data_err = 0; ob_last_err = 0; ob_done_t = -1;
        ob_aw_seen = 0; ob_ar_seen = 0; ob_resp = 2'b11; ob_done_after = 1'b1;
        ob_ready_at_done = 1'b0; ob_busy_ready = 1'b0; ob_addr = '1; ob_len = '0; ob_size = '0; ob_burst = '0;
        cmd_valid = 1; cmd_rd = rd; cmd_addr = addr; cmd_len = len;
        t = 0;
        while (!cmd_ready && t < 100) begin @(posedge clk_if); #1; t++; end
        @(posedge clk_if); #1;
        cmd_valid = 0; cmd_addr = $urandom; cmd_len = 8'($urandom);
        wb = 0; rb = 0; ar_ok = 0; wdone = 0; hold_r = 0; hold_b = 0;
        t = 0;
        while (t < 3000) begin
            if (done_valid) begin
                ob_done_t = t; ob_resp = done_resp; ob_ready_at_done = cmd_ready;
                break;
            end
            if (cmd_ready) ob_busy_ready = 1'b1;
            if (reset_wbeat >= 0 && wb == reset_wbeat) begin
                resetn = 0;
                break;
            end
            m_axi_awready = 1'($urandom_range(0, 1));
            m_axi_arready = 1'($urandom_range(0, 1));
            m_axi_wready  = 1'($urandom_range(0, 1));
            wr_valid = 1; wr_strb = '1;
            wr_data = (wb <= 255) ? wmem[wb] : '0;
            if (!hold_r) m_axi_rvalid = ar_ok && (rb <= int'(len)) && 1'($urandom_range(0, 1));
            m_axi_rdata = rmem[rb % 256];
            m_axi_rresp = (rb == err_beat) ? 2'(err_val) : 2'b00;
            m_axi_rlast = (early_beat >= 0) ? (rb == early_beat) : (rb == int'(len));
            rd_ready = toggle ? (t % 2 == 0) : 1'($urandom_range(0, 1));
            if (!hold_b) m_axi_bvalid = wdone && 1'($urandom_range(0, 1));
            m_axi_bresp = bresp_cfg;
            #1;
            if (m_axi_awvalid) begin
                if (ob_aw_seen == 0) begin
                    ob_addr = m_axi_awaddr; ob_len = m_axi_awlen; ob_size = m_axi_awsize; ob_burst = m_axi_awburst;
                end
                ob_aw_seen++;
            end
            if (m_axi_arvalid) begin
                if (ob_ar_seen == 0) begin
                    ob_addr = m_axi_araddr; ob_len = m_axi_arlen; ob_size = m_axi_arsize; ob_burst = m_axi_arburst;
                end
                ob_ar_seen++;
                if (m_axi_arready) ar_ok = 1;
            end
            hold_r = m_axi_rvalid && !m_axi_rready;
            hold_b = m_axi_bvalid && !m_axi_bready;
            if (m_axi_wvalid && m_axi_wready) begin
                if (wb > 255 || m_axi_wdata !== wmem[wb]) ob_data_err++;
                if (m_axi_wlast !== (wb == int'(len))) ob_last_err++;
                wb++;
                if (wb == int'(len) + 1) wdone = 1;
            end
            if (rd_valid && rd_ready) begin
                if (rb > 255 || rd_data !== rmem[rb]) ob_data_err++;
                if (rd_last !== (rb == int'(len))) ob_last_err++;
                rb++;
            end
            @(posedge clk_if); #1; t++;
        end
        ob_wbeats = wb; ob_rbeats = rb;
        if (reset_wbeat < 0 && ob_done_t >= 0) begin
            clear_inputs();
            @(posedge clk_if); #1;
            ob_done_after = done_valid;
        end
        clear_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        repeat (3) @(posedge clk_if);
        #1;
        n_vec++; if ({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, rd_valid, done_valid, wr_ready, m_axi_bready, m_axi_rready} !== 8'h00) begin
            n_err++; $display("FAIL reset_valids: got %b expected 00000000", {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, rd_valid, done_valid, wr_ready, m_axi_bready, m_axi_rready});
        end
        n_vec++; if ({rd_last, done_resp} !== 3'b000) begin n_err++; $display("FAIL reset_last_resp: got %b expected 000", {rd_last, done_resp}); end
        n_vec++; if (stat_rd_beats !== 0 || stat_wr_beats !== 0) begin n_err++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_rd_beats, stat_wr_beats); end
        resetn = 1;
        @(posedge clk_if); #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        exp_rd_stats = 0; exp_wr_stats = 0;
    endtask

    task automatic test_write_burst();
        bresp_cfg = 2'b00;
        run_cmd(0, 32'h1000, 8'd3, -1, 0, -1, 0, -1);
        n_vec++; if (ob_done_t < 0) begin n_err++; $display("FAIL wr_timeout: done never seen"); end
        n_vec++; if ({ob_addr, ob_len, ob_size, ob_burst} !== {32'h1000, 8'd3, 3'd4, 2'b01}) begin
            n_err++; $display("FAIL wr_aw_fields: got %h/%0d/%0d/%0d expected 1000/3/4/1", ob_addr, ob_len, ob_size, ob_burst);
        end
        n_vec++; if (ob_wbeats !== 4) begin n_err++; $display("FAIL wr_beats: got %0d expected 4", ob_wbeats); end
        n_vec++; if (ob_data_err + ob_last_err !== 0) begin n_err++; $display("FAIL wr_data_last: got %0d/%0d errors expected 0", ob_data_err, ob_last_err); end
        n_vec++; if (ob_resp !== 2'b00) begin n_err++; $display("FAIL wr_resp: got %b expected 00", ob_resp); end
        n_vec++; if (ob_ar_seen !== 0) begin n_err++; $display("FAIL wr_no_ar: got %0d expected 0", ob_ar_seen); end
        n_vec++; if (ob_busy_ready !== 1'b0) begin n_err++; $display("FAIL wr_busy_ready: got %b expected 0", ob_busy_ready); end
        n_vec++; if (ob_done_after !== 1'b0) begin n_err++; $display("FAIL wr_done_pulse: got %b expected 0", ob_done_after); end
        exp_wr_stats += 4;
    endtask

    task automatic test_read_burst();
        run_cmd(1, 32'h2000, 8'd7, -1, 0, -1, 1, -1);
        n_vec++; if ({ob_addr, ob_len, ob_size, ob_burst} !== {32'h2000, 8'd7, 3'd4, 2'b01}) begin
            n_err++; $display("FAIL rd_ar_fields: got %h/%0d/%0d/%0d expected 2000/7/4/1", ob_addr, ob_len, ob_size, ob_burst);
        end
        n_vec++; if (ob_rbeats !== 8) begin n_err++; $display("FAIL rd_beats: got %0d expected 8", ob_rbeats); end
        n_vec++; if (ob_data_err + ob_last_err !== 0) begin n_err++; $display("FAIL rd_data_last: got %0d/%0d errors expected 0", ob_data_err, ob_last_err); end
        n_vec++; if (ob_resp !== 2'b00) begin n_err++; $display("FAIL rd_resp: got %b expected 00", ob_resp); end
        n_vec++; if (ob_ready_at_done !== 1'b1) begin n_err++; $display("FAIL rd_b2b_ready: got %b expected 1", ob_ready_at_done); end
        exp_rd_stats += 8;
    endtask

    task automatic test_4k_boundary();
        run_cmd(0, 32'h0FF0, 8'd1, -1, 0, -1, 0, -1);
        n_vec++; if (ob_aw_seen !== 0) begin n_err++; $display("FAIL 4k_no_aw: got %0d expected 0", ob_aw_seen); end
        n_vec++; if (ob_done_t !== 0) begin n_err++; $display("FAIL 4k_done_latency: got %0d expected 0", ob_done_t); end
        n_vec++; if (ob_resp !== 2'b10) begin n_err++; $display("FAIL 4k_resp: got %b expected 10", ob_resp); end
        n_vec++; if (ob_done_after !== 1'b0) begin n_err++; $display("FAIL 4k_done_pulse: got %b expected 0", ob_done_after); end
        // exact fit up to the page end is legal
        run_cmd(0, 32'h0FE0, 8'd1, -1, 0, -1, 0, -1);
        n_vec++; if (ob_wbeats !== 2 || ob_resp !== 2'b00) begin n_err++; $display("FAIL 4k_exact_fit: got %0d beats resp %b expected 2 beats resp 00", ob_wbeats, ob_resp); end
        exp_wr_stats += 2;
        // 256-beat read filling a whole page
        run_cmd(1, 32'h7000, 8'd255, -1, 0, -1, 0, -1);
        n_vec++; if (ob_rbeats !== 256 || ob_last_err !== 0 || ob_data_err !== 0) begin
            n_err++; $display("FAIL max_len_read: got %0d beats %0d/%0d errors expected 256 beats 0 errors", ob_rbeats, ob_data_err, ob_last_err);
        end
        exp_rd_stats += 256;
    endtask

    task automatic test_read_errors();
        run_cmd(1, 32'h3000, 8'd3, 1, 2, -1, 0, -1);
        n_vec++; if (ob_resp !== 2'b10 || ob_rbeats !== 4) begin n_err++; $display("FAIL rd_rresp_err: got resp %b beats %0d expected 10/4", ob_resp, ob_rbeats); end
        run_cmd(1, 32'h3040, 8'd3, -1, 0, 2, 0, -1);
        n_vec++; if (ob_resp !== 2'b10 || ob_rbeats !== 4) begin n_err++; $display("FAIL rd_rlast_early: got resp %b beats %0d expected 10/4", ob_resp, ob_rbeats); end
        exp_rd_stats += 8;
    endtask

    task automatic test_random();
        bit rd;
        logic [AW-1:0] a;
        int len, eb, ev, early, beats;
        logic [1:0] er;
        for (int k = 0; k < 24; k++) begin
            rd = 1'($urandom_range(0, 1));
            a = $urandom & 32'h0000_FFFF;
            len = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 80);
            eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
            ev = $urandom_range(1, 3);
            early = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
            bresp_cfg = 2'($urandom_range(0, 3));
            run_cmd(rd, a, 8'(len), eb, ev, early, 0, -1);
            beats = model_cross(a, len) ? 0 : len + 1;
            er = model_cross(a, len) ? 2'b10 : (rd ? model_read_resp(len, eb, ev, early) : bresp_cfg);
            n_vec++; if (ob_resp !== er) begin n_err++; $display("FAIL rand_resp[%0d]: got %b expected %b", k, ob_resp, er); end
            n_vec++; if ((rd ? ob_rbeats : ob_wbeats) !== beats || ob_data_err + ob_last_err !== 0) begin
                n_err++; $display("FAIL rand_beats[%0d]: got %0d beats %0d errors expected %0d beats 0 errors", k, rd ? ob_rbeats : ob_wbeats, ob_data_err + ob_last_err, beats);
            end
            if (beats > 0) begin
                n_vec++; if (ob_addr !== (a & ~32'(SW - 1)) || ob_len !== 8'(len)) begin
                    n_err++; $display("FAIL rand_addr[%0d]: got %h/%0d expected %h/%0d", k, ob_addr, ob_len, a & ~32'(SW - 1), len);
                end
            end
            if (rd) exp_rd_stats += beats; else exp_wr_stats += beats;
        end
    endtask

    task automatic test_stats();
        n_vec++; if (stat_rd_beats !== 32'(stat_exp(exp_rd_stats))) begin n_err++; $display("FAIL stat_rd: got %0d expected %0d", stat_rd_beats, stat_exp(exp_rd_stats)); end
        n_vec++; if (stat_wr_beats !== 32'(stat_exp(exp_wr_stats))) begin n_err++; $display("FAIL stat_wr: got %0d expected %0d", stat_wr_beats, stat_exp(exp_wr_stats)); end
    endtask

    task automatic test_reset_midburst();
        bresp_cfg = 2'b00;
        run_cmd(0, 32'h4000, 8'd3, -1, 0, -1, 0, 1);
        @(posedge clk_if); #1;
        n_vec++; if ({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, rd_valid, done_valid, wr_ready, m_axi_bready, m_axi_rready, m_axi_wlast} !== 9'h000) begin
            n_err++; $display("FAIL midreset_valids: got %b expected 000000000", {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, rd_valid, done_valid, wr_ready, m_axi_bready, m_axi_rready, m_axi_wlast});
        end
        n_vec++; if (stat_rd_beats !== 0 || stat_wr_beats !== 0) begin n_err++; $display("FAIL midreset_stats: got %0d/%0d expected 0/0", stat_rd_beats, stat_wr_beats); end
        resetn = 1;
        exp_rd_stats = 0; exp_wr_stats = 0;
        @(posedge clk_if); #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midreset_cmd_ready: got %b expected 1", cmd_ready); end
        run_cmd(0, 32'h5000, 8'd2, -1, 0, -1, 0, -1);
        n_vec++; if (ob_wbeats !== 3 || ob_resp !== 2'b00) begin n_err++; $display("FAIL midreset_recover: got %0d beats resp %b expected 3/00", ob_wbeats, ob_resp); end
        exp_wr_stats += 3;
    endtask

    initial begin
        bresp_cfg = 2'b00;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_4k_boundary();
        test_read_errors();
        test_stats();
        test_random();
        test_stats();
        test_reset_midburst();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
